// File: rtl/tick_scheduler_pkg.sv
// Shared definitions for the tick scheduler block.
//   - Default parameter values for channel count, counter width and prescaler.
//   - Config FSM state type.
//   - Channel-index width constant and a helper that sizes an index safely.
package tick_scheduler_pkg;

  localparam int DEF_NUM_CH   = 4;
  localparam int DEF_CNT_W    = 32;
  localparam int DEF_PRESCALE = 50000;
  localparam int DEF_PRE_W    = 16;

  // Width of an in-range channel index for the default channel count.
  localparam int CH_W = $clog2(DEF_NUM_CH);

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } cfg_state_t;

  // Index width for n channels, never narrower than one bit.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_scheduler_if.sv
// Config port of the tick scheduler.
//   cfg_valid   master->slave  request valid
//   cfg_ready   slave->master  port can accept a request
//   cfg_ch      master->slave  target channel (out-of-range values allowed)
//   cfg_period  master->slave  channel period in base ticks, 0 disables
//   cfg_run     master->slave  channel run bit
//   cfg_err     slave->master  one-cycle pulse on an out-of-range request
//   cfg_pending slave->master  an accepted request awaits a base tick
interface tick_scheduler_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
);
  logic                      cfg_valid;
  logic                      cfg_ready;
  logic [$clog2(NUM_CH):0]   cfg_ch;
  logic [CNT_W-1:0]          cfg_period;
  logic                      cfg_run;
  logic                      cfg_err;
  logic                      cfg_pending;

  modport master (
    output cfg_valid, cfg_ch, cfg_period, cfg_run,
    input  cfg_ready, cfg_err, cfg_pending
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_period, cfg_run,
    output cfg_ready, cfg_err, cfg_pending
  );
endinterface

// File: rtl/tick_channel.sv
// One rate channel of the tick scheduler.
//   clock, reset   system clock and synchronous active-high reset
//   base_tick      one-cycle shared time-base pulse; the channel only moves on it
//   apply          load apply_period/apply_run and zero the counter on this base tick
//   apply_period   new period in base ticks (0 disables)
//   apply_run      new run bit
//   tick           registered one-cycle pulse every period base ticks
//   led            toggles on every tick, resets high
module tick_channel #(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             base_tick,
  input  logic             apply,
  input  logic [CNT_W-1:0] apply_period,
  input  logic             apply_run,
  output logic             tick,
  output logic             led
);

  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] cnt;
  logic             run;

  always_ff @(posedge clock) begin
    if (reset) begin
      period <= '0;
      cnt    <= '0;
      run    <= 1'b0;
      tick   <= 1'b0;
      led    <= 1'b1;
    end else begin
      tick <= 1'b0;
      if (base_tick) begin
        if (apply) begin
          // A new setting takes this base tick for itself: no advance, no tick.
          period <= apply_period;
          run    <= apply_run;
          cnt    <= '0;
        end else if (run && (period != '0)) begin
          if (cnt == period - CNT_W'(1)) begin
            cnt  <= '0;
            tick <= 1'b1;
            led  <= ~led;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: rtl/tick_scheduler.sv
// Shared time-base controller: one prescaler producing a base tick, fanned out
// to NUM_CH independently programmable rate channels.
//   clock, reset  system clock and synchronous active-high reset
//   enable        global run enable; low freezes prescaler, channels and apply
//   cfg           config port (slave side), see tick_scheduler_if
//   base_tick     one-cycle pulse every PRESCALE enabled cycles
//   tick          per-channel registered tick pulse
//   led           per-channel output toggling on each channel tick
// Accepted settings are held until the next base tick so a channel never
// changes rate in the middle of a base-tick period.
module tick_scheduler
  import tick_scheduler_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int PRESCALE = DEF_PRESCALE,
  parameter int PRE_W    = DEF_PRE_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  tick_scheduler_if.slave   cfg,
  output logic              base_tick,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] led
);

  localparam int                 IDX_W    = ch_idx_w(NUM_CH);
  localparam int                 CHIN_W   = $clog2(NUM_CH) + 1;
  localparam logic [CHIN_W-1:0]  NUM_CH_V = CHIN_W'(NUM_CH);
  localparam logic [PRE_W-1:0]   PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] pre_cnt;

  cfg_state_t       state;
  logic [IDX_W-1:0] lat_ch;
  logic [CNT_W-1:0] lat_period;
  logic             lat_run;

  logic [NUM_CH-1:0] apply;

  // Prescaler: base_tick marks the last enabled cycle of each PRESCALE window.
  assign base_tick = enable && (pre_cnt == PRE_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      pre_cnt <= '0;
    end else if (enable) begin
      pre_cnt <= base_tick ? '0 : pre_cnt + PRE_W'(1);
    end
  end

  // Config FSM: accept in IDLE, hold the request in PENDING until a base tick.
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      lat_ch          <= '0;
      lat_period      <= '0;
      lat_run         <= 1'b0;
      cfg.cfg_ready   <= 1'b1;
      cfg.cfg_err     <= 1'b0;
      cfg.cfg_pending <= 1'b0;
    end else begin
      cfg.cfg_err <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg.cfg_valid && cfg.cfg_ready) begin
            if (cfg.cfg_ch < NUM_CH_V) begin
              lat_ch          <= cfg.cfg_ch[IDX_W-1:0];
              lat_period      <= cfg.cfg_period;
              lat_run         <= cfg.cfg_run;
              state           <= PENDING;
              cfg.cfg_ready   <= 1'b0;
              cfg.cfg_pending <= 1'b1;
            end else begin
              cfg.cfg_err <= 1'b1;
            end
          end
        end
        PENDING: begin
          if (base_tick) begin
            state           <= IDLE;
            cfg.cfg_ready   <= 1'b1;
            cfg.cfg_pending <= 1'b0;
          end
        end
        default: begin
          state           <= IDLE;
          cfg.cfg_ready   <= 1'b1;
          cfg.cfg_pending <= 1'b0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign apply[i] = (state == PENDING) && base_tick && (lat_ch == IDX_W'(i));

    tick_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clock        (clock),
      .reset        (reset),
      .base_tick    (base_tick),
      .apply        (apply[i]),
      .apply_period (lat_period),
      .apply_run    (lat_run),
      .tick         (tick[i]),
      .led          (led[i])
    );
  end

endmodule

// File: doc/tick_scheduler.md
Name: tick_scheduler

Overview:
Shared time-base controller for the clock simulator. It runs one prescaler that produces a base tick, and splits that tick into NUM_CH independently programmable rate channels, one each for seconds LED, blink, display refresh and buzzer. Each channel produces a one-cycle tick enable and a toggling LED-style output. Channel periods and run bits are written through a valid/ready config port. New settings are applied only on a base-tick boundary, so an output never glitches mid-period.

Parameters:
NUM_CH, 4, number of rate channels
CNT_W, 32, width of per-channel period and counter
PRESCALE, 50000, clock cycles per base tick (must be >= 2)
PRE_W, 16, prescaler counter width (must hold PRESCALE-1)

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
enable  in  1  global run enable; low freezes the prescaler, channels and pending apply
cfg_valid  in  1  config request valid
cfg_ready  out  1  config port can accept
cfg_ch  in  $clog2(NUM_CH)+1  target channel; out-of-range values are legal input
cfg_period  in  CNT_W  channel period in base ticks; 0 means disabled
cfg_run  in  1  channel run bit
cfg_err  out  1  one-cycle pulse: accepted request had cfg_ch >= NUM_CH
cfg_pending  out  1  an accepted config is waiting for a base tick
base_tick  out  1  one-cycle pulse per PRESCALE enabled cycles
tick  out  NUM_CH  per-channel one-cycle tick pulse (registered)
led  out  NUM_CH  per-channel output; toggles on each tick of its channel

Behaviour:
- Reset values: prescaler=0; all periods=0; run=0; channel counters=0; tick=0; base_tick=0; led=all 1s; cfg_ready=1; cfg_err=0; cfg_pending=0; FSM=IDLE. Reset overrides every other event in the same cycle, including mid-pending config, which is discarded.
- Prescaler:
  - When enable=1, it counts 0..PRESCALE-1.
  - base_tick is high in the cycle the count equals PRESCALE-1 and enable=1. The count wraps to 0 on the next edge.
  - When enable=0, the count holds and base_tick=0.
- Channel i, evaluated only in cycles where base_tick=1:
  - If run=0 or period=0, the counter holds and no tick is produced.
  - Else if counter==period-1: counter<=0, tick[i]<=1 on the next edge, led[i]<=~led[i] on the same edge.
  - Else counter<=counter+1.
  - tick[i] is 0 in every other cycle.
  - Steady-state tick interval is period*PRESCALE cycles. period=1 produces a tick after every base tick.
- Config FSM, states IDLE and PENDING:
  - IDLE: cfg_ready=1. On cfg_valid&&cfg_ready:
    - If cfg_ch < NUM_CH: latch ch/period/run, then go to PENDING (cfg_ready=0, cfg_pending=1 from the next cycle).
    - If cfg_ch >= NUM_CH: cfg_err=1 for one cycle, nothing latched, stay IDLE.
  - PENDING: cfg_ready=0, and cfg_valid is ignored. In the first cycle with base_tick=1, the latched values are written to the channel and its counter is forced to 0. The FSM returns to IDLE on that edge (cfg_ready=1 next cycle).
- Simultaneous apply and base_tick on a channel: apply wins. That channel does not advance or tick on this base tick. Other channels advance normally.
- Applying run=0 or period=0 clears the counter. The led level holds.
- Arithmetic: counter and period are unsigned CNT_W. The counter never exceeds period-1 because it is zeroed on apply. No other wrap path exists.

Decomposition:
- Package tick_scheduler_pkg holds:
  - default NUM_CH, CNT_W, PRESCALE constants
  - cfg FSM state enum {IDLE, PENDING}
  - channel-index width constant
- Sub-module tick_channel, one instance per channel, contains the period/run registers, counter, tick and led flops. Its inputs are base_tick, apply, apply_period and apply_run.
- The prescaler and config FSM live in the top module.

Test Plan:
- PRESCALE=4; after reset, write ch0 period=3 run=1 -> applied at the first base_tick; first tick[0] 12 cycles later; then one tick every 12 cycles; led[0] goes 1->0->1.
- Write ch2 while ch0 is running with period=3 -> ch0 tick spacing stays unchanged; cfg_ready low from acceptance until the apply edge; cfg_pending high over the same window.
- cfg_ch=5 with NUM_CH=4 -> cfg_err pulses for exactly one cycle; cfg_ready stays 1; no channel changes.
- Hold enable=0 for 10 cycles mid-period, including during PENDING -> no base_tick or tick; the next tick is delayed by exactly 10 cycles; the apply happens after re-enable.
- Rewrite running ch1 (period 5) with period=2 -> counter restarts at the apply base tick; next tick[1] comes 2 base ticks later; no tick on the apply base tick.
- Assert reset for 1 cycle while PENDING with led[0]=0 -> led=all 1s, periods=0, cfg_ready=1 next cycle, no ticks afterwards.
